// File: rtl/hdmi_pattern_gen.sv
// Video timing and test-pattern generator with registered outputs (one-clock latency).
// Define HDMI_PATTERN_BORDER_EN to overlay a one-pixel white border on the active area.
module hdmi_pattern_gen #(
   parameter int H_ACTIVE = 64,
   parameter int H_FP     = 4,
   parameter int H_SYNC   = 8,
   parameter int H_BP     = 4,
   parameter int V_ACTIVE = 64,
   parameter int V_FP     = 2,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 2
) (
   input  logic       hdmi_clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   output logic       hdmi_de,
   output logic       hdmi_hs,
   output logic       hdmi_vs,
   output logic [7:0] hdmi_r,
   output logic [7:0] hdmi_g,
   output logic [7:0] hdmi_b,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
`ifdef HDMI_PATTERN_BORDER_EN
   localparam logic [HW-1:0] H_ALAST = HW'(H_ACTIVE - 1);
   localparam logic [VW-1:0] V_ALAST = VW'(V_ACTIVE - 1);
`endif

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   logic [1:0]    pat;
   logic [7:0]    pat_val;
   logic          h_wrap;
   logic          f_wrap;
   logic          latch;

   logic          de_d;
   logic          hs_d;
   logic          vs_d;
   logic          fs_d;
   logic [23:0]   rgb_d;
   logic [7:0]    x8;
   logic [7:0]    y8;
   logic [2:0]    bar;

   assign h_wrap = (hcnt == H_LAST);
   assign f_wrap = h_wrap && (vcnt == V_LAST);
   assign latch  = enable && ((state == IDLE) || f_wrap);

   always_ff @(posedge hdmi_clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (enable) state_nxt = RUN;
         RUN:     if (f_wrap && !enable) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge hdmi_clk or posedge rst) begin
      if (rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (state == RUN) begin
         if (h_wrap) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
         end else begin
            hcnt <= hcnt + HW'(1);
         end
      end else begin
         hcnt <= '0;
         vcnt <= '0;
      end
   end

   // pat_val is the count this frame's start will produce
   always_ff @(posedge hdmi_clk or posedge rst) begin
      if (rst) begin
         pat     <= '0;
         pat_val <= '0;
      end else if (latch) begin
         pat     <= pattern_sel;
         pat_val <= frame_cnt + 8'd1;
      end
   end

   always_comb begin
      x8    = 8'(hcnt);
      y8    = 8'(vcnt);
      bar   = 3'(hcnt / HW'(BAR_W));
      de_d  = 1'b0;
      hs_d  = 1'b0;
      vs_d  = 1'b0;
      fs_d  = 1'b0;
      rgb_d = '0;
      if (state == RUN) begin
         de_d = (hcnt < H_ACT) && (vcnt < V_ACT);
         hs_d = (hcnt >= H_SS) && (hcnt < H_SE);
         vs_d = (vcnt >= V_SS) && (vcnt < V_SE);
         fs_d = (hcnt == '0) && (vcnt == '0);
         if (de_d) begin
            unique case (pat)
               2'd0:    rgb_d = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
               2'd1:    rgb_d = {x8, y8, 8'h00};
               2'd2:    rgb_d = {24{x8[3] ^ y8[3]}};
               default: rgb_d = {3{pat_val}};
            endcase
`ifdef HDMI_PATTERN_BORDER_EN
            if ((hcnt == '0) || (hcnt == H_ALAST) ||
                (vcnt == '0) || (vcnt == V_ALAST))
               rgb_d = '1;
`endif
         end
      end
   end

   always_ff @(posedge hdmi_clk or posedge rst) begin
      if (rst) begin
         hdmi_de     <= 1'b0;
         hdmi_hs     <= 1'b0;
         hdmi_vs     <= 1'b0;
         hdmi_r      <= '0;
         hdmi_g      <= '0;
         hdmi_b      <= '0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         hdmi_de     <= de_d;
         hdmi_hs     <= hs_d;
         hdmi_vs     <= vs_d;
         hdmi_r      <= rgb_d[23:16];
         hdmi_g      <= rgb_d[15:8];
         hdmi_b      <= rgb_d[7:0];
         frame_start <= fs_d;
         if (frame_start) frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Bench for hdmi_pattern_gen: pixel-index reference model checked every clock,
// plus directed timing, pattern, enable-drop and reset checks.
module tb_hdmi_pattern_gen;

   localparam int HA = 64, HF = 4, HS = 8, HB = 4;
   localparam int VA = 64, VF = 2, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic       hdmi_clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [1:0] pattern_sel = 2'd0;
   logic       hdmi_de, hdmi_hs, hdmi_vs, frame_start;
   logic [7:0] hdmi_r, hdmi_g, hdmi_b, frame_cnt;

   hdmi_pattern_gen dut (
      .hdmi_clk    (hdmi_clk),
      .rst         (rst),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .hdmi_de     (hdmi_de),
      .hdmi_hs     (hdmi_hs),
      .hdmi_vs     (hdmi_vs),
      .hdmi_r      (hdmi_r),
      .hdmi_g      (hdmi_g),
      .hdmi_b      (hdmi_b),
      .frame_start (frame_start),
      .frame_cnt   (frame_cnt)
   );

   always #5 hdmi_clk = ~hdmi_clk;

   int errors = 0;
   int checks = 0;

   // model: running flag, linear pixel index in frame, latched pattern
   bit         m_run, m_fs;
   int         m_p, m_pat;
   logic [7:0] m_val, m_fcnt;
   logic       e_de, e_hs, e_vs, e_fs;
   logic [23:0] e_rgb;

   int step_no = 0, last_fs = 0, fs_gap = 0;
   int de_run = 0, de_prev = 0;
   int n;

   function automatic logic [23:0] pix_rgb(int x, int y, int pat, logic [7:0] v);
      logic [23:0] c;
      case (pat)
         0: case (x / (HA / 8))
               0: c = 24'hFFFFFF;
               1: c = 24'hFFFF00;
               2: c = 24'h00FFFF;
               3: c = 24'h00FF00;
               4: c = 24'hFF00FF;
               5: c = 24'hFF0000;
               6: c = 24'h0000FF;
               default: c = 24'h000000;
            endcase
         1: c = {8'(x), 8'(y), 8'h00};
         2: c = (((x / 8) + (y / 8)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
         default: c = {v, v, v};
      endcase
`ifdef HDMI_PATTERN_BORDER_EN
      if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) c = 24'hFFFFFF;
`endif
      return c;
   endfunction

   task automatic model_reset();
      m_run = 0; m_fs = 0; m_p = 0; m_pat = 0;
      m_val = 0; m_fcnt = 0;
      e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_rgb = 0;
   endtask

   task automatic model_edge();
      int x, y;
      logic [7:0] old;
      x = m_p % HT;
      y = m_p / HT;
      old = m_fcnt;
      if (m_fs) m_fcnt = m_fcnt + 8'd1;
      e_de  = m_run && (x < HA) && (y < VA);
      e_hs  = m_run && (x >= HA + HF) && (x < HA + HF + HS);
      e_vs  = m_run && (y >= VA + VF) && (y < VA + VF + VS);
      e_fs  = m_run && (m_p == 0);
      e_rgb = e_de ? pix_rgb(x, y, m_pat, m_val) : 24'h0;
      m_fs  = e_fs;
      if (!m_run) begin
         if (enable) begin
            m_run = 1; m_p = 0; m_pat = pattern_sel; m_val = old + 8'd1;
         end
      end else if (m_p == FT - 1) begin
         m_p = 0;
         if (enable) begin
            m_pat = pattern_sel; m_val = old + 8'd1;
         end else begin
            m_run = 0;
         end
      end else begin
         m_p++;
      end
   endtask

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge hdmi_clk);
      if (!rst) model_edge();
      #1;
      step_no++;
      if (frame_start) begin
         fs_gap = step_no - last_fs;
         last_fs = step_no;
         de_prev = de_run;
         de_run = 0;
      end
      if (hdmi_de) de_run++;
      chk("pixel",
          {frame_start, hdmi_de, hdmi_hs, hdmi_vs, hdmi_r, hdmi_g, hdmi_b, frame_cnt},
          {e_fs, e_de, e_hs, e_vs, e_rgb, m_fcnt});
   endtask

   task automatic advance(int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic wait_fs(output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!frame_start && cnt < FT + 20);
   endtask

   initial begin
      model_reset();
      advance(3);
      rst = 1'b0;
      advance(4);

      enable = 1'b1;
      pattern_sel = 2'd0;
      wait_fs(n);
      chk("first_fs_latency", n, 2);
      chk("bar0_white", {hdmi_r, hdmi_g, hdmi_b}, 24'hFFFFFF);
      advance(1);
      chk("fcnt_after_fs", frame_cnt, 1);
      advance(7);
      chk("bar1_yellow", {hdmi_r, hdmi_g, hdmi_b}, 24'hFFFF00);
      advance(48);
      chk("bar7_black", {hdmi_de, hdmi_r, hdmi_g, hdmi_b}, {1'b1, 24'h000000});

      pattern_sel = 2'd2;
      wait_fs(n);
      pattern_sel = 2'($urandom);
      advance(8);
      chk("checker_8_0", {hdmi_r, hdmi_g, hdmi_b}, 24'hFFFFFF);
      advance(8 * HT);
      chk("checker_8_8", {hdmi_de, hdmi_r, hdmi_g, hdmi_b}, {1'b1, 24'h000000});

      for (int i = 0; i < 2; i++) begin
         advance($urandom_range(10, FT - 2000));
         pattern_sel = 2'($urandom);
         wait_fs(n);
         chk("fs_period", fs_gap, FT);
         chk("de_per_frame", de_prev, HA * VA);
      end

      pattern_sel = 2'd1;
      wait_fs(n);
      advance(2005);
      chk("fcnt_is_5", frame_cnt, 5);
      chk("pat1_mid", {hdmi_r, hdmi_g, hdmi_b}, 24'h051900);
      pattern_sel = 2'd3;
      advance(1);
      chk("pat1_after_sel", {hdmi_r, hdmi_g, hdmi_b}, 24'h061900);
      wait_fs(n);
      chk("pat3_value", {hdmi_r, hdmi_g, hdmi_b}, 24'h060606);
      chk("fs_period_p3", fs_gap, FT);

      advance(10 * HT);
      enable = 1'b0;
      pattern_sel = 2'($urandom);
      advance(FT - 10 * HT + 50);
      chk("de_last_frame", de_run, HA * VA);
      chk("idle_outputs",
          {frame_start, hdmi_de, hdmi_hs, hdmi_vs, hdmi_r, hdmi_g, hdmi_b}, 0);
      chk("fcnt_hold", frame_cnt, 6);

      enable = 1'b1;
      wait_fs(n);
      chk("restart_latency", n, 2);
      advance(300);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_async_outputs",
          {frame_start, hdmi_de, hdmi_hs, hdmi_vs, hdmi_r, hdmi_g, hdmi_b}, 0);
      chk("rst_fcnt", frame_cnt, 0);
      advance(2);
      rst = 1'b0;
      wait_fs(n);
      chk("post_rst_latency", n, 2);
      advance(100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
